// File: rtl/cla_linear_part.sv
// Linear (XOR) recombination stage of the decomposed carry-lookahead adder.
// Optional consistency check enabled by defining CLA_LIN_CHECK_EN.
module cla_linear_part #(
  parameter int unsigned NBIT = 4,
  parameter int unsigned NNL  = 56
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [NBIT-1:0] a_i,
  input  logic [NBIT-1:0] b_i,
  input  logic            c_i,
  input  logic [NNL-1:0]  n_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [NBIT-1:0] s_o,
  output logic            cout_o,
  output logic            err_o
);

  localparam int unsigned NnlExp = 2 ** (NBIT + 2) - NBIT - 4;
  localparam int unsigned KW     = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic [KW-1:0] KMax = KW'(NBIT - 1);

  if (NNL != NnlExp) begin : g_bad_nnl
    $error("cla_linear_part: NNL must equal 2^(NBIT+2) - NBIT - 4");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEval = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NBIT-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [NNL-1:0]  n_q, n_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   kcnt_q, kcnt_d;
  logic [NBIT-1:0] blk_par;

  // blk_par[j] is the carry into bit j+1: parity of term block j+1.
  for (genvar k = 1; k <= NBIT; k++) begin : g_blk
    localparam int unsigned Off = 2 ** (k + 1) - k - 3;
    localparam int unsigned Len = 2 ** (k + 1) - 1;
    assign blk_par[k-1] = ^n_q[Off +: Len];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    s_d     = s_q;
    carry_d = carry_q;
    kcnt_d  = kcnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          n_d     = n_i;
          carry_d = c_i;
          kcnt_d  = '0;
          state_d = StEval;
        end
      end
      StEval: begin
        s_d[kcnt_q] = a_q[kcnt_q] ^ b_q[kcnt_q] ^ carry_q;
        carry_d     = blk_par[kcnt_q];
        if (kcnt_q == KMax) begin
          state_d = StDone;
        end else begin
          kcnt_d = kcnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      kcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      kcnt_q  <= kcnt_d;
    end
  end

`ifdef CLA_LIN_CHECK_EN
  logic err_q, err_d, maj;

  // The true carry is the majority function; a mismatch means a corrupted term vector.
  always_comb begin
    maj   = (a_q[kcnt_q] & b_q[kcnt_q]) | (a_q[kcnt_q] & carry_q) | (b_q[kcnt_q] & carry_q);
    err_d = err_q;
    if (state_q == StIdle && in_valid_i) begin
      err_d = 1'b0;
    end else if (state_q == StEval && maj != blk_par[kcnt_q]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign s_o         = s_q;
  assign cout_o      = carry_q;

endmodule

// File: tb/tb_cla_linear_part.sv
// Self-checking bench for cla_linear_part: directed vectors, random operands,
// corrupted term vectors, backpressure and asynchronous reset mid-transaction.
module tb_cla_linear_part;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  a, b, s;
  logic        c, cout, err;
  logic [55:0] n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_linear_part dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .n_i        (n),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .s_o        (s),
    .cout_o     (cout),
    .err_o      (err)
  );

  // Build the term vector from the recursive product-term definition.
  function automatic logic [55:0] build_n(input logic [3:0] aa, input logic [3:0] bb,
                                          input logic cc);
    logic prev[$];
    logic cur[$];
    logic [55:0] v;
    int idx;
    v = '0;
    idx = 0;
    prev = {cc};
    for (int k = 1; k <= 4; k++) begin
      cur = {};
      cur.push_back(aa[k-1] & bb[k-1]);
      foreach (prev[i]) cur.push_back(aa[k-1] & prev[i]);
      foreach (prev[i]) cur.push_back(bb[k-1] & prev[i]);
      foreach (cur[i]) begin
        v[idx] = cur[i];
        idx++;
      end
      prev = cur;
    end
    return v;
  endfunction

  // Reference for arbitrary (possibly corrupted) term vectors: carries are block parities.
  function automatic void ref_model(input logic [3:0] aa, input logic [3:0] bb, input logic cc,
                                    input logic [55:0] nn, output logic [3:0] es,
                                    output logic ecout, output logic eerr);
    int off;
    int len;
    logic car;
    logic nxt;
    logic mj;
    off = 0;
    car = cc;
    eerr = 1'b0;
    es = '0;
    for (int k = 0; k < 4; k++) begin
      len = (1 << (k + 2)) - 1;
      nxt = 1'b0;
      for (int i = 0; i < len; i++) nxt ^= nn[off+i];
      es[k] = aa[k] ^ bb[k] ^ car;
      mj = (aa[k] & bb[k]) | (aa[k] & car) | (bb[k] & car);
      if (mj != nxt) eerr = 1'b1;
      car = nxt;
      off += len;
    end
    ecout = car;
`ifndef CLA_LIN_CHECK_EN
    eerr = 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; returns observed outputs and capture-to-valid latency.
  task automatic run_txn(input logic [3:0] aa, input logic [3:0] bb, input logic cc,
                         input logic [55:0] nn, output logic [3:0] rs, output logic rcout,
                         output logic rerr, output int lat);
    int guard;
    a = aa; b = bb; c = cc; n = nn;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    rs = s; rcout = cout; rerr = err;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = 1'b0; n = '0;
    #12;
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (s !== 4'h0) begin failures++; $display("FAIL reset_s got=%h exp=0", s); end
    if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [3:0] va[4] = '{4'h5, 4'hF, 4'hF, 4'h0};
    logic [3:0] vb[4] = '{4'h3, 4'h1, 4'hF, 4'h0};
    logic       vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] es[4] = '{4'b1000, 4'h0, 4'hF, 4'h1};
    logic       ec[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] rs;
    logic rc, re;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_txn(va[i], vb[i], vc[i], build_n(va[i], vb[i], vc[i]), rs, rc, re, lat);
      checks += 4;
      if (rs !== es[i]) begin failures++; $display("FAIL dir%0d_s got=%h exp=%h", i, rs, es[i]); end
      if (rc !== ec[i]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", i, rc, ec[i]); end
      if (re !== 1'b0) begin failures++; $display("FAIL dir%0d_err got=%b exp=0", i, re); end
      if (lat != 4) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_in_ready_after got=%b exp=1", i, in_ready);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb, rs;
    logic rcin, rc, re;
    logic [4:0] sum;
    int lat;
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rcin = 1'($urandom_range(0, 1));
      sum = 5'(ra) + 5'(rb) + 5'(rcin);
      run_txn(ra, rb, rcin, build_n(ra, rb, rcin), rs, rc, re, lat);
      checks += 3;
      if ({rc, rs} !== sum) begin
        failures++;
        $display("FAIL rand%0d_sum a=%h b=%h c=%b got=%b_%h exp=%h", i, ra, rb, rcin, rc, rs, sum);
      end
      if (re !== 1'b0) begin failures++; $display("FAIL rand%0d_err got=%b exp=0", i, re); end
      if (lat != 4) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=4", i, lat); end
    end
  endtask

  task automatic test_fault();
    logic [55:0] nn;
    logic [3:0] ra, rb, rs, es;
    logic rcin, rc, re, ec, ee, exp_err;
    int lat;
    // a=2, b=2 with n[3] inverted: c2 collapses to 0.
    nn = build_n(4'h2, 4'h2, 1'b0);
    nn[3] = ~nn[3];
`ifdef CLA_LIN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_txn(4'h2, 4'h2, 1'b0, nn, rs, rc, re, lat);
    checks += 3;
    if (rs !== 4'h0) begin failures++; $display("FAIL fault_s got=%h exp=0", rs); end
    if (rc !== 1'b0) begin failures++; $display("FAIL fault_cout got=%b exp=0", rc); end
    if (re !== exp_err) begin failures++; $display("FAIL fault_err got=%b exp=%b", re, exp_err); end
    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rcin = 1'($urandom_range(0, 1));
      nn = build_n(ra, rb, rcin);
      nn[$urandom_range(0, 55)] ^= 1'b1;
      ref_model(ra, rb, rcin, nn, es, ec, ee);
      run_txn(ra, rb, rcin, nn, rs, rc, re, lat);
      checks += 3;
      if (rs !== es) begin failures++; $display("FAIL rfault%0d_s got=%h exp=%h", i, rs, es); end
      if (rc !== ec) begin failures++; $display("FAIL rfault%0d_cout got=%b exp=%b", i, rc, ec); end
      if (re !== ee) begin failures++; $display("FAIL rfault%0d_err got=%b exp=%b", i, re, ee); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    a = 4'h9; b = 4'h8; c = 1'b1; n = build_n(4'h9, 4'h8, 1'b1);
    in_valid = 1'b1;
    step();
    // New data held on the bus throughout DONE must not be captured.
    a = 4'h3; b = 4'h4; c = 1'b0; n = build_n(4'h3, 4'h4, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      step();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_out_valid got=%b exp=1", i, out_valid); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready got=%b exp=0", i, in_ready); end
      if (s !== 4'h2) begin failures++; $display("FAIL bp%0d_s got=%h exp=2", i, s); end
      if (cout !== 1'b1) begin failures++; $display("FAIL bp%0d_cout got=%b exp=1", i, cout); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_out_valid got=%b exp=0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_recapture got=%b exp=0", in_ready); end
    guard = 0;
    while (!out_valid && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if ({cout, s} !== 5'h07) begin failures++; $display("FAIL bp_next_sum got=%b_%h exp=07", cout, s); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] rs;
    logic rc, re;
    int lat;
    a = 4'h1; b = 4'h0; c = 1'b0; n = build_n(4'h1, 4'h0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    // Now in the second EVAL cycle with s[0]=1 already written.
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    if (s !== 4'h0) begin failures++; $display("FAIL midrst_s got=%h exp=0", s); end
    if (cout !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b exp=0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'h6, 4'h7, 1'b1, build_n(4'h6, 4'h7, 1'b1), rs, rc, re, lat);
    checks += 2;
    if ({rc, rs} !== 5'h0E) begin failures++; $display("FAIL midrst_after got=%b_%h exp=0e", rc, rs); end
    if (lat != 4) begin failures++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_fault();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_linear_part.md
# cla_linear_part

Linear (XOR) recombination stage of the decomposed carry-lookahead adder. It accepts the non-linear product-term vector produced by the non-linear generator, together with the operands and carry-in. It XOR-reduces one carry block per cycle to rebuild the carry chain, then returns the sum and carry-out over a valid/ready handshake. It is the consumer side of the non-linear term bus and closes the decomposed-adder datapath.

## Interface
- NBIT, 4, adder width in bits.
- NNL, 56, number of non-linear terms.
  - Must equal 2^(NBIT+2) - NBIT - 4.
  - Any other value is an elaboration error.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream has a transaction.
- in_ready  output  1  block can capture a transaction.
- a  input  NBIT  operand A.
- b  input  NBIT  operand B.
- c  input  1  carry-in c0.
- n  input  NNL  non-linear term vector.
- out_valid  output  1  s, cout and err are valid.
- out_ready  input  1  downstream accepts the result.
- s  output  NBIT  sum.
- cout  output  1  carry-out c_NBIT.
- err  output  1  consistency-check flag (see Configuration).

## Operation
- Term layout is fixed. Carry c_k (k = 1..NBIT) is the XOR of block k:
  - Block k occupies n[O_k +: 2^(k+1)-1], with O_k = 2^(k+1) - k - 3.
  - Block 1 = n[2:0]; block 2 = n[9:3]; block 3 = n[24:10]; block 4 = n[55:25].
  - Within block k: index 0 = a[k-1]&b[k-1]; next the a[k-1]-products of block k-1's terms in order; then the b[k-1]-products in the same order. Block 0 is the single term c.
- States:
  - IDLE: in_ready=1. On in_valid, capture a, b, c, n into registers; carry_r <= c; kcnt <= 0; clear err; go to EVAL.
  - EVAL: in_ready=0. Each cycle:
    - s_r[kcnt] <= a_r[kcnt] ^ b_r[kcnt] ^ carry_r.
    - carry_r <= XOR of block kcnt+1 of the captured n.
    - kcnt increments. When kcnt == NBIT-1, go to DONE.
  - DONE: out_valid=1; cout = carry_r. When out_ready=1, go to IDLE.
- s, cout and err hold their values in IDLE until the next capture overwrites them. s is updated bit-serially during EVAL.
- Block parities are computed combinationally from the captured n and selected by kcnt.
- kcnt is ceil(log2(NBIT)) bits wide (1 bit when NBIT=1) and never wraps past NBIT-1.
- Inputs are ignored outside IDLE. No transaction is queued or dropped silently: upstream holds until in_ready.

## Timing
- Reset values:
  - state = IDLE, so in_ready=1.
  - out_valid=0, s=0, cout=0, err=0, kcnt=0, carry_r=0.
- Capture happens at edge E0 (in_valid & in_ready).
- EVAL occupies edges E1..E_NBIT. out_valid rises after E_NBIT (NBIT cycles after capture).
- Handshake completes on the edge with out_valid & out_ready. in_ready rises the following cycle.
  - No same-cycle result/accept overlap.
  - Minimum period is NBIT+2 cycles per transaction.
- out_ready low in DONE: hold all outputs stable indefinitely.
- rst_n asserted mid-EVAL or in DONE: immediately (asynchronously) return to reset values. The partial transaction is discarded. After deassertion, the first edge can capture.
- out_valid and in_ready are registered-state decodes with no combinational path from in_valid or out_ready.

## Configuration
- CLA_LIN_CHECK_EN defined:
  - Each EVAL cycle also computes maj(a_r[kcnt], b_r[kcnt], carry_r).
  - If that differs from the block kcnt+1 parity, err is set (sticky until the next capture). err is valid with out_valid.
- Not defined: the check logic is absent and err is tied 0. Port list and timing are identical.

## Test plan
- a=5, b=3, c=0, consistent n -> s=4'b1000, cout=0, err=0; out_valid 4 cycles after capture.
- a=F, b=1, c=0 -> s=0, cout=1.
- a=F, b=F, c=1 -> s=F, cout=1.
- a=0, b=0, c=1 -> s=1, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 held throughout -> s/cout stable, in_ready=0, no capture. After out_ready=1, the next transaction is captured one cycle after handshake.
- Fault and reset:
  - a=2, b=2, c=0 with n[3] inverted -> c2 reads 0, so s=0 instead of 4. err=1 with CLA_LIN_CHECK_EN, err=0 without.
  - Separately, rst_n low at EVAL cycle 2 -> out_valid=0, in_ready=1, s=0 immediately.
